imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
- Synthesizable program loader for the 54-instruction MIPS multicycle CPU; it is the writer side of the instruction memory.
- Receives a framed byte stream (from a UART RX or debug bridge), assembles big-endian 32-bit instruction words and writes them sequentially into imem from address 0.
- Holds the CPU in reset until a complete, checksum-valid image is loaded, then releases it.
- Replaces hex preloading on FPGA builds.

Parameters:
- ADDR_W, 13, imem word-address width (capacity 2^ADDR_W words).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000000, max clk cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- start  in  1  one-cycle pulse; re-arms the loader from DONE/ERR to IDLE.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  drives the CPU reset.
- done  out  1  image loaded and verified.
- error  out  1  frame error latched.

Behaviour:
- Reset values (asynchronous, immediate on reset assertion, including mid-frame):
  - state=IDLE; in_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; cpu_hold=1; done=0; error=0.
  - word count, byte index, checksum and timeout counter all 0.
- Byte acceptance: a byte is accepted only in a cycle where in_valid=1 and in_ready=1.
- in_ready is 1 in IDLE, CNT_HI, CNT_LO, DATA and CHK; it is 0 in DONE and ERR.
- Frame format: SYNC, CNT_HI, CNT_LO, then N×4 payload bytes (MSB first), then CHK.
  - N = {CNT_HI, CNT_LO}.
  - CHK = 8-bit sum, modulo 256, of the payload bytes only.
- IDLE:
  - Accepted byte == SYNC_BYTE -> CNT_HI.
  - Any other byte is discarded; the state stays IDLE.
- CNT_HI -> CNT_LO on an accepted byte.
- CNT_LO, on an accepted byte (N is now complete), goes to exactly one of:
  - ERR if N > 2^ADDR_W.
  - CHK if N == 0.
  - DATA otherwise.
- DATA:
  - Shift the byte into the word register and add it to the checksum.
  - On the 4th byte of a word, the next cycle has imem_we=1, imem_addr=word index, imem_wdata=assembled word.
  - Word index then increments; imem_addr holds its last value while imem_we=0.
  - After word N-1 is written -> CHK.
  - The write pulse and acceptance of the next byte may happen in the same cycle (full throughput: 1 byte/clk).
- CHK, on an accepted byte:
  - Byte equals the running sum -> DONE.
  - Otherwise -> ERR.
- DONE: done=1, cpu_hold=0. cpu_hold deasserts in the cycle after the CHK byte is accepted.
- ERR: error=1, cpu_hold=1, done=0. Words already written are not erased.
- start pulse in DONE or ERR:
  - Next state IDLE; clear done and error; set cpu_hold=1.
  - Clear the counters and the checksum.
  - start is ignored in all other states.
- Timeout:
  - In CNT_HI, CNT_LO, DATA and CHK, the counter increments every cycle without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT -> ERR.
  - The counter does not run in IDLE.
- Simultaneous events: reset dominates start; start dominates nothing else.

Decomposition:
- Shared package cpu54_pkg holds:
  - Loader state enum (IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR).
  - SYNC_BYTE default.
  - IMEM_DEPTH = 8192.
- One natural sub-module, stream_word_packer: 8->32 big-endian byte packer with byte counter and word_valid pulse.
- The FSM, checksum and timeout stay in the top module.

Test Plan:
- Nominal load: bytes A5 00 02 20 01 00 01 20 02 00 02 46 at 1 byte/clk -> exactly two write strobes, addr0=20010001 and addr1=20020002; done=1 and cpu_hold=0 the cycle after the 46 byte.
- Bad checksum: same frame with last byte 47 -> error=1, cpu_hold=1, done=0. Then pulse start and resend the correct frame -> done=1.
- Zero-length and garbage prefix: bytes 00 FF A5 00 00 00 -> no imem_we; done=1.
- Oversize count with ADDR_W=2: A5 00 05 -> ERR immediately after the CNT_LO byte, no writes. A5 00 04 plus 16 payload bytes plus checksum -> 4 writes at addresses 0..3, done=1.
- Stalls and timeout with TIMEOUT=16: gaps of 10 idle cycles between bytes -> correct load. A 16-cycle gap mid-word -> ERR; the partial word is never written.
- Reset mid-frame: assert reset after the 6th byte -> all outputs return to reset values the same cycle. A full frame resent after reset loads correctly from address 0.

Source files
------------

// File: rtl/imem_stream_loader_pkg.sv
// Shared types for the imem program loader: loader FSM states,
// default frame sync byte and instruction memory depth.
package cpu54_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int IMEM_DEPTH = 8192;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte stream in (in_data/in_valid/in_ready) and imem write port out.
// master: stream source / imem sink; slave: the loader.
interface imem_stream_loader_if
  import cpu54_pkg::*;
#(
  parameter int ADDR_W = $clog2(IMEM_DEPTH)
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_stream_loader_packer.sv
// 8->32 big-endian byte packer. Ports: din/din_valid in, word +
// one-cycle word_valid out (cycle after 4th byte), last = 4th byte now.
module stream_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last
);
  logic [23:0] sh;
  logic [1:0]  cnt;

  assign last = din_valid && (cnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh         <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (din_valid) begin
        sh  <= {sh[15:0], din};
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          word       <= {sh, din};
          word_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/imem_stream_loader.sv
// Framed-stream program loader: writes imem from address 0 and holds
// the CPU in reset until a checksum-valid image is in. Ports: clk,
// reset, bus (stream in / imem out), start, cpu_hold, done, error.
module imem_stream_loader
  import cpu54_pkg::*;
#(
  parameter int         ADDR_W    = $clog2(IMEM_DEPTH),
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  imem_stream_loader_if.slave bus,
  input  logic                start,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);
  localparam int TW = $clog2(TIMEOUT + 1);

  loader_state_t     state;
  logic [15:0]       n;
  logic [15:0]       idx;
  logic [7:0]        sum;
  logic [TW-1:0]     tmo;
  logic [ADDR_W-1:0] addr;
  logic              acc;
  logic              active;
  logic              pk_last;
  logic              pk_valid;
  logic [31:0]       pk_word;
  logic [15:0]       cnt_full;
  logic              too_big;

  assign bus.in_ready = (state != DONE) && (state != ERR);
  assign acc          = bus.in_valid && bus.in_ready;
  assign active       = state inside {CNT_HI, CNT_LO, DATA, CHK};
  // n[15:8] already holds CNT_HI while the CNT_LO byte is on the bus
  assign cnt_full     = {n[15:8], bus.in_data};
  assign too_big      = {1'b0, cnt_full} > (17'd1 << ADDR_W);

  assign bus.imem_we    = pk_valid;
  assign bus.imem_wdata = pk_word;
  assign bus.imem_addr  = addr;

  stream_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == IDLE),
    .din        (bus.in_data),
    .din_valid  (acc && (state == DATA)),
    .word       (pk_word),
    .word_valid (pk_valid),
    .last       (pk_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      n        <= '0;
      idx      <= '0;
      sum      <= '0;
      tmo      <= '0;
      addr     <= '0;
    end else begin
      if (active) begin
        if (acc) begin
          tmo <= '0;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          state <= ERR;
          error <= 1'b1;
        end else begin
          tmo <= tmo + TW'(1);
        end
      end
      unique case (state)
        IDLE: begin
          if (acc && (bus.in_data == SYNC_BYTE)) state <= CNT_HI;
        end
        CNT_HI: begin
          if (acc) begin
            n     <= {bus.in_data, 8'h00};
            state <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (acc) begin
            n <= cnt_full;
            unique case (1'b1)
              too_big: begin
                state <= ERR;
                error <= 1'b1;
              end
              (cnt_full == 16'd0): state <= CHK;
              default: state <= DATA;
            endcase
          end
        end
        DATA: begin
          if (acc) begin
            sum <= sum + bus.in_data;
            // write lands next cycle; addr is set to match it
            if (pk_last) begin
              addr <= idx[ADDR_W-1:0];
              idx  <= idx + 16'd1;
              if (idx == n - 16'd1) state <= CHK;
            end
          end
        end
        CHK: begin
          if (acc) begin
            if (bus.in_data == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (start) begin
            state    <= IDLE;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            n        <= '0;
            idx      <= '0;
            sum      <= '0;
            tmo      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader (ADDR_W=2, TIMEOUT=16) with a
// write scoreboard fed by the stimulus and drained by an imem monitor.
module tb_imem_stream_loader;
  localparam int AW = 2;

  logic clk;
  logic reset;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] exp_q[$];
  logic [7:0]     fq[$];
  logic [31:0]    wq[$];

  imem_stream_loader_if #(.ADDR_W(AW)) bus ();

  imem_stream_loader #(
    .ADDR_W  (AW),
    .TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .start    (start),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.imem_we === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0h:%0h expected=none",
               bus.imem_addr, bus.imem_wdata);
      end
      if (exp_q.size() > 0) begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({bus.imem_addr, bus.imem_wdata} === e) else begin
          errors++;
          $error("FAIL write observed=%0h:%0h expected=%0h:%0h",
                 bus.imem_addr, bus.imem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i], 0);
  endtask

  task automatic load_words(input logic [31:0] w[$], input int gap,
                            input logic bad);
    logic [7:0]  s;
    logic [15:0] cnt;
    s   = 8'h00;
    cnt = 16'(w.size());
    send(8'hA5, gap);
    send(cnt[15:8], gap);
    send(cnt[7:0], gap);
    foreach (w[i]) begin
      exp_q.push_back({AW'(i), w[i]});
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b = w[i][8*k +: 8];
        s = s + b;
        send(b, gap);
      end
    end
    send(bad ? s + 8'd1 : s, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (2) @(posedge clk);
    #1;
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // nominal two-word load
    wq = '{32'h20010001, 32'h20020002};
    load_words(wq, 0, 1'b0);
    chk("nom_done", 64'(done), 64'd1);
    chk("nom_hold", 64'(cpu_hold), 64'd0);
    chk("nom_error", 64'(error), 64'd0);
    chk("nom_ready", 64'(bus.in_ready), 64'd0);
    drain("nom_sb");

    // bad checksum, then re-arm and resend
    pulse_start();
    chk("start_done", 64'(done), 64'd0);
    chk("start_hold", 64'(cpu_hold), 64'd1);
    load_words(wq, 0, 1'b1);
    chk("bad_error", 64'(error), 64'd1);
    chk("bad_hold", 64'(cpu_hold), 64'd1);
    chk("bad_done", 64'(done), 64'd0);
    drain("bad_sb");
    pulse_start();
    chk("rearm_error", 64'(error), 64'd0);
    load_words(wq, 0, 1'b0);
    chk("resend_done", 64'(done), 64'd1);
    drain("resend_sb");

    // zero-length frame behind garbage
    pulse_start();
    fq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_bytes(fq);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_hold", 64'(cpu_hold), 64'd0);
    drain("zero_sb");

    // oversize count, then exactly full imem
    pulse_start();
    fq = '{8'hA5, 8'h00, 8'h05};
    send_bytes(fq);
    chk("over_error", 64'(error), 64'd1);
    chk("over_ready", 64'(bus.in_ready), 64'd0);
    pulse_start();
    wq = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    load_words(wq, 0, 1'b0);
    chk("full_done", 64'(done), 64'd1);
    drain("full_sb");

    // stalls of 10 cycles between bytes
    pulse_start();
    wq = '{32'hDEADBEEF, 32'h0000FF01};
    load_words(wq, 10, 1'b0);
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_error", 64'(error), 64'd0);
    drain("stall_sb");

    // 16-cycle gap mid-word times out, partial word never written
    pulse_start();
    fq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
    send_bytes(fq);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_15", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    chk("tmo_16", 64'(error), 64'd1);
    chk("tmo_hold", 64'(cpu_hold), 64'd1);
    drain("tmo_sb");

    // asynchronous reset mid-frame, then full reload from address 0
    pulse_start();
    fq = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00};
    send_bytes(fq);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_we", 64'(bus.imem_we), 64'd0);
    chk("mid_addr", 64'(bus.imem_addr), 64'd0);
    chk("mid_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("mid_hold", 64'(cpu_hold), 64'd1);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_error", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    wq = '{32'h20010001, 32'h20020002};
    load_words(wq, 0, 1'b0);
    chk("reload_done", 64'(done), 64'd1);
    drain("reload_sb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
